// File: rtl/cache_perf_pkg.sv
// cache_perf_pkg: FSM states, snapshot read selectors and selector count shared by cache_perf_mon
package cache_perf_pkg;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD} perf_state_e;
  typedef enum logic [2:0] {SEL_ACC, SEL_HIT, SEL_MISS, SEL_CYC, SEL_STALL} rd_sel_e;
  localparam int NUM_SEL = 5;
endpackage

// File: rtl/perf_sat_counter.sv
// perf_sat_counter: saturating event counter; d_o is the next value so callers can snapshot the
// current cycle's event, sat_o flags that the counter sits at all-ones.
module perf_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] d_o,
  output logic         sat_o
);
  logic [W-1:0] cnt_q;
  assign d_o = clr_i ? '0 : (inc_i && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  assign sat_o = &d_o;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) cnt_q <= '0;
    else cnt_q <= d_o;
endmodule

// File: rtl/cache_perf_mon.sv
// cache_perf_mon: per-channel cache access/hit/miss/cycle counters with windowed runs and snapshot reads.
// Define PERF_MISS_LAT_EN to add the miss_stall_i port and per-channel stall counters.
module cache_perf_mon
  import cache_perf_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 32,
  parameter int WIN_W  = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      start_i,
  input  logic                      stop_i,
  input  logic                      clear_i,
  input  logic [WIN_W-1:0]          win_len_i,
  input  logic [NUM_CH-1:0]         acc_vld_i,
  input  logic [NUM_CH-1:0]         acc_hit_i,
`ifdef PERF_MISS_LAT_EN
  input  logic [NUM_CH-1:0]         miss_stall_i,
`endif
  input  logic [$clog2(NUM_CH)-1:0] rd_ch_i,
  input  logic [2:0]                rd_sel_i,
  output logic [CNT_W-1:0]          rd_data_o,
  output logic                      busy_o,
  output logic                      win_done_o,
  output logic [NUM_CH-1:0]         ovf_o
);
  perf_state_e state_q, state_d;
  logic [WIN_W-1:0] win_len_q, win_len_d, win_cnt_q, win_cnt_d;
  logic win_done_q, win_done_d;
  logic [NUM_CH-1:0] ovf_q, ovf_d;
  logic [CNT_W-1:0] rd_data_q, rd_data_d;
  logic [CNT_W-1:0] snap_q [NUM_CH][NUM_SEL];
  logic [CNT_W-1:0] live_d [NUM_CH][NUM_SEL];
  logic sat [NUM_CH][NUM_SEL];
  logic run, enter, wend, take, rd_ok;
  assign run = state_q == S_RUN && !clear_i;
  assign enter = state_q != S_RUN && start_i && !stop_i && !clear_i;
  assign wend = run && win_len_q != '0 && win_cnt_q == win_len_q - 1'b1;
  assign take = run && (stop_i || wend);
  assign state_d = clear_i ? S_IDLE : enter ? S_RUN : take ? S_HOLD : state_q;
  assign win_len_d = enter ? win_len_i : win_len_q;
  assign win_cnt_d = enter ? '0 : run ? win_cnt_q + 1'b1 : win_cnt_q;
  assign win_done_d = wend;
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [3:0] ev;
    assign ev = {4{run}} & {1'b1, acc_vld_i[c] & ~acc_hit_i[c], acc_vld_i[c] & acc_hit_i[c], acc_vld_i[c]};
    for (genvar s = 0; s < 4; s++) begin : g_sel
      perf_sat_counter #(.W(CNT_W)) u_cnt (
        .clk_i, .rst_i, .clr_i(clear_i | enter), .inc_i(ev[s]), .d_o(live_d[c][s]), .sat_o(sat[c][s])
      );
    end
`ifdef PERF_MISS_LAT_EN
    perf_sat_counter #(.W(CNT_W)) u_stall (
      .clk_i, .rst_i, .clr_i(clear_i | enter), .inc_i(run & miss_stall_i[c]),
      .d_o(live_d[c][SEL_STALL]), .sat_o(sat[c][SEL_STALL])
    );
`else
    assign live_d[c][SEL_STALL] = '0;
    assign sat[c][SEL_STALL] = 1'b0;
`endif
  end
  always_comb begin
    ovf_d = ovf_q;
    for (int c = 0; c < NUM_CH; c++)
      for (int s = 0; s < NUM_SEL; s++)
        ovf_d[c] = ovf_d[c] | sat[c][s];
    ovf_d = clear_i ? '0 : ovf_d;
  end
  assign rd_ok = int'(rd_ch_i) < NUM_CH && int'(rd_sel_i) < NUM_SEL;
  assign rd_data_d = rd_ok ? snap_q[rd_ch_i][rd_sel_i] : '0;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state_q <= S_IDLE;
      win_len_q <= '0;
      win_cnt_q <= '0;
      win_done_q <= 1'b0;
      ovf_q <= '0;
      rd_data_q <= '0;
    end else begin
      state_q <= state_d;
      win_len_q <= win_len_d;
      win_cnt_q <= win_cnt_d;
      win_done_q <= win_done_d;
      ovf_q <= ovf_d;
      rd_data_q <= rd_data_d;
    end
  // live_d is already zero during clear, so one copy path serves both snapshot and clear
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      for (int c = 0; c < NUM_CH; c++)
        for (int s = 0; s < NUM_SEL; s++)
          snap_q[c][s] <= '0;
    end else if (clear_i || take) begin
      snap_q <= live_d;
    end
  assign busy_o = state_q == S_RUN;
  assign win_done_o = win_done_q;
  assign ovf_o = ovf_q;
  assign rd_data_o = rd_data_q;
endmodule

// File: tb/tb_cache_perf_mon.sv
// tb_cache_perf_mon: randomized and directed bench for cache_perf_mon with a queue-based read scoreboard.
module tb_cache_perf_mon;
  localparam int NCH = 2, CW = 8, WW = 16;
  localparam int unsigned MAXV = (1 << CW) - 1;
`ifdef PERF_MISS_LAT_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif
  typedef struct {string nm; int unsigned exp;} exp_t;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, stop = 1'b0, clear = 1'b0;
  logic [WW-1:0] win_len = '0;
  logic [NCH-1:0] vld = '0, hit = '0, stall = '0, ovf;
  logic [0:0] rd_ch = '0;
  logic [2:0] rd_sel = '0;
  logic [CW-1:0] rd_data;
  logic busy, win_done, rd_en = 1'b0, rd_pend, use_c = 1'b0;
  int unsigned cexp = 0;
  int n_cmp = 0, n_err = 0, wd_cnt;
  exp_t rq[$];
  int unsigned live[NCH][5], snap[NCH][5], runcnt, winlen;
  bit running, exp_wd;
  bit [NCH-1:0] exp_ovf;

  always #5 clk = ~clk;

  cache_perf_mon #(.NUM_CH(NCH), .CNT_W(CW), .WIN_W(WW)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop), .clear_i(clear),
    .win_len_i(win_len), .acc_vld_i(vld), .acc_hit_i(hit),
`ifdef PERF_MISS_LAT_EN
    .miss_stall_i(stall),
`endif
    .rd_ch_i(rd_ch), .rd_sel_i(rd_sel), .rd_data_o(rd_data),
    .busy_o(busy), .win_done_o(win_done), .ovf_o(ovf)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  always @(posedge clk or posedge rst) rd_pend <= rst ? 1'b0 : rd_en;

  always @(negedge clk)
    if (rd_pend) begin
      exp_t e;
      if (rq.size() == 0) chk("rd_queue_underrun", 1, 0);
      else begin
        e = rq.pop_front();
        chk(e.nm, {24'd0, rd_data}, e.exp);
      end
    end

  task automatic model_zero(input bit also_snap);
    foreach (live[c, s]) begin
      live[c][s] = 0;
      if (also_snap) snap[c][s] = 0;
    end
  endtask

  task automatic bump(input int c, input int s, input bit e);
    if (e) begin
      if (live[c][s] < MAXV) live[c][s]++;
      if (live[c][s] == MAXV) exp_ovf[c] = 1'b1;
    end
  endtask

  task automatic step();
    exp_wd = 1'b0;
    if (clear) begin
      model_zero(1'b1);
      exp_ovf = '0;
      running = 1'b0;
    end else if (running) begin
      for (int c = 0; c < NCH; c++) begin
        bump(c, 0, vld[c]);
        bump(c, 1, vld[c] & hit[c]);
        bump(c, 2, vld[c] & ~hit[c]);
        bump(c, 3, 1'b1);
        bump(c, 4, stall[c] & STALL_EN);
      end
      runcnt++;
      exp_wd = winlen != 0 && runcnt == winlen;
      if (stop || exp_wd) begin
        snap = live;
        running = 1'b0;
      end
    end else if (start && !stop) begin
      running = 1'b1;
      model_zero(1'b0);
      runcnt = 0;
      winlen = win_len;
    end
  endtask

  task automatic tick();
    if (rd_en) begin
      exp_t e;
      e.nm = $sformatf("rd_ch%0d_sel%0d", rd_ch, rd_sel);
      e.exp = 0;
      if (use_c) e.exp = cexp;
      else if (rd_sel < 5) e.exp = snap[rd_ch][rd_sel];
      rq.push_back(e);
    end
    step();
    @(posedge clk);
    #1;
    chk("busy", busy, running);
    chk("win_done", win_done, exp_wd);
    chk("ovf", ovf, exp_ovf);
    start = 0; stop = 0; clear = 0; rd_en = 0; use_c = 0;
  endtask

  task automatic rd_const(input int c, input int s, input int unsigned v);
    rd_ch = 1'(c); rd_sel = 3'(s); rd_en = 1; use_c = 1; cexp = v;
    tick();
  endtask

  task automatic read_all();
    for (int c = 0; c < NCH; c++)
      for (int s = 0; s < 8; s++) begin
        rd_ch = 1'(c); rd_sel = 3'(s); rd_en = 1;
        tick();
      end
  endtask

  initial begin
    int n;
    for (int i = 0; i < 3; i++) begin
      vld = ~vld; hit = ~hit;
      @(posedge clk);
      #1;
    end
    chk("rst_busy", busy, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_win_done", win_done, 0);
    chk("rst_rd_data", rd_data, 0);
    rst = 0; vld = 0; hit = 0;
    read_all();
    // free-running count, stop on the 20th run cycle
    win_len = 0; start = 1; tick();
    for (int i = 0; i < 20; i++) begin
      vld[0] = i < 10; hit[0] = i < 7; stop = i == 19;
      tick();
    end
    vld = 0; hit = 0;
    rd_const(0, 0, 10); rd_const(0, 1, 7); rd_const(0, 2, 3); rd_const(0, 3, 20); rd_const(1, 0, 0);
    // eight-cycle window with continuous ch1 hits
    win_len = 8; start = 1; tick();
    vld[1] = 1; hit[1] = 1; wd_cnt = 0;
    for (int i = 0; i < 14; i++) begin
      tick();
      wd_cnt += int'(win_done);
    end
    chk("win_pulse_count", wd_cnt, 1);
    chk("win_busy_dropped", busy, 0);
    vld = 0; hit = 0;
    rd_const(1, 0, 8); rd_const(1, 1, 8); rd_const(1, 2, 0); rd_const(1, 3, 8);
    // clear beats stop beats start
    win_len = 0; start = 1; tick();
    vld = 2'b11; hit = 2'b01;
    repeat (5) tick();
    clear = 1; stop = 1; start = 1; tick();
    chk("prec_busy", busy, 0);
    chk("prec_win_done", win_done, 0);
    vld = 0; hit = 0;
    rd_const(0, 0, 0); rd_const(0, 3, 0); rd_const(1, 0, 0); rd_const(1, 1, 0);
    // saturation of ch0 access counter
    start = 1; tick();
    vld[0] = 1;
    for (int i = 0; i < 300; i++) begin
      stop = i == 299;
      tick();
    end
    vld = 0;
    rd_const(0, 0, MAXV); rd_const(0, 2, MAXV); rd_const(0, 1, 0);
    chk("sat_ovf0", ovf[0], 1);
    repeat (3) tick();
    chk("sat_ovf0_held", ovf[0], 1);
    clear = 1; tick();
    chk("clr_ovf", ovf, 0);
    // miss-stall level counting
    start = 1; tick();
    stall[0] = 1;
    repeat (5) tick();
    stall[0] = 0;
    repeat (3) tick();
    stop = 1; tick();
    rd_const(0, 4, STALL_EN ? 5 : 0); rd_const(1, 4, 0); rd_const(0, 5, 0); rd_const(1, 7, 0);
    // randomized runs against the model
    for (int it = 0; it < 30; it++) begin
      win_len = $urandom_range(0, 1) ? WW'($urandom_range(1, 20)) : '0;
      start = 1; tick();
      n = $urandom_range(1, 30);
      for (int i = 0; i < n; i++) begin
        vld = NCH'($urandom); hit = NCH'($urandom); stall = NCH'($urandom);
        stop = (i == n - 1) && ($urandom_range(0, 1) == 1);
        if ($urandom_range(0, 7) == 0) start = 1;
        if ($urandom_range(0, 60) == 0) clear = 1;
        if ($urandom_range(0, 3) == 0) begin
          rd_ch = 1'($urandom); rd_sel = 3'($urandom); rd_en = 1;
        end
        tick();
      end
      vld = 0; hit = 0; stall = 0;
      read_all();
    end
    // asynchronous reset in the middle of a run
    win_len = 0; start = 1; tick();
    vld = 2'b11; hit = 2'b10; stall = 2'b01;
    repeat (4) tick();
    #2 rst = 1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_ovf", ovf, 0);
    chk("arst_rd_data", rd_data, 0);
    chk("arst_win_done", win_done, 0);
    model_zero(1'b1);
    running = 0; exp_ovf = '0; rq.delete();
    @(posedge clk);
    #1;
    rst = 0; vld = 0; hit = 0; stall = 0;
    read_all();
    repeat (3) tick();
    chk("rd_queue_drained", rq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
